// File: rtl/pll_lock_supervisor.sv
// Lock-qualification supervisor between the PLL and the core reset input.
// It synchronises the PLL lock flags, re-arms the sticky-lock flag and releases a clean core reset.
module pll_lock_supervisor #(
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int STDY_RST_CYCLES    = 2,
  parameter int STDY_TIMEOUT       = 64,
  parameter int HOLDOFF_CYCLES     = 16,
  parameter int CNT_W              = 8
) (
  input  logic             clock_in,
  input  logic             rst_n_in,
  input  logic             pll_locked,
  input  logic             pll_locked_stdy,
  input  logic             clear_lost,
  output logic             stdy_rst,
  output logic             sys_rst_n,
  output logic             ready,
  output logic             lost_lock,
  output logic [CNT_W-1:0] unlock_count
);

  localparam int MAX_A   = (LOCK_STABLE_CYCLES > STDY_RST_CYCLES) ? LOCK_STABLE_CYCLES : STDY_RST_CYCLES;
  localparam int MAX_B   = (STDY_TIMEOUT > HOLDOFF_CYCLES) ? STDY_TIMEOUT : HOLDOFF_CYCLES;
  localparam int MAX_CNT = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CTR_W   = $clog2(MAX_CNT + 1);

  localparam logic [CTR_W-1:0] CTR_ZERO    = CTR_W'(0);
  localparam logic [CTR_W-1:0] CTR_ONE     = CTR_W'(1);
  localparam logic [CTR_W-1:0] STABLE_LAST = CTR_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CTR_W-1:0] ARM_LAST    = CTR_W'(STDY_RST_CYCLES - 1);
  localparam logic [CTR_W-1:0] TIMEOUT_LAST = CTR_W'(STDY_TIMEOUT - 1);
  localparam logic [CTR_W-1:0] HOLDOFF_LAST = CTR_W'(HOLDOFF_CYCLES - 1);

  localparam logic [CNT_W-1:0] UC_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] UC_MAX = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    S_WAIT_LOCK = 3'd0,
    S_STABLE    = 3'd1,
    S_ARM       = 3'd2,
    S_WAIT_STDY = 3'd3,
    S_RUN       = 3'd4,
    S_HOLDOFF   = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [CTR_W-1:0] cnt_q, cnt_d;
  logic             lock_meta_q, lock_s_q;
  logic             stdy_meta_q, stdy_s_q;
  logic             stdy_rst_q, stdy_rst_d;
  logic             sys_rst_n_q, sys_rst_n_d;
  logic             ready_q, ready_d;
  logic             lost_lock_q, lost_lock_d;
  logic [CNT_W-1:0] unlock_count_q, unlock_count_d;
  logic             loss_s;

  // Two-flop synchronisers for the asynchronous PLL flags
  always_ff @(posedge clock_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
      stdy_meta_q <= 1'b0;
      stdy_s_q    <= 1'b0;
    end else begin
      lock_meta_q <= pll_locked;
      lock_s_q    <= lock_meta_q;
      stdy_meta_q <= pll_locked_stdy;
      stdy_s_q    <= stdy_meta_q;
    end
  end

  // Next-state, shared cycle counter and next output values
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    loss_s         = 1'b0;
    case (state_q)
      S_WAIT_LOCK: begin
        cnt_d = CTR_ZERO;
        if (lock_s_q) begin
          state_d = S_STABLE;
        end else begin
          state_d = S_WAIT_LOCK;
        end
      end
      S_STABLE: begin
        if (!lock_s_q) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = CTR_ZERO;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = S_ARM;
          cnt_d   = CTR_ZERO;
        end else begin
          cnt_d = cnt_q + CTR_ONE;
        end
      end
      S_ARM: begin
        if (!lock_s_q) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = CTR_ZERO;
        end else if (cnt_q == ARM_LAST) begin
          state_d = S_WAIT_STDY;
          cnt_d   = CTR_ZERO;
        end else begin
          cnt_d = cnt_q + CTR_ONE;
        end
      end
      S_WAIT_STDY: begin
        // Losing lock here takes priority over a late steady flag
        if (!lock_s_q) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = CTR_ZERO;
        end else if (stdy_s_q) begin
          state_d = S_RUN;
          cnt_d   = CTR_ZERO;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = CTR_ZERO;
        end else begin
          cnt_d = cnt_q + CTR_ONE;
        end
      end
      S_RUN: begin
        cnt_d = CTR_ZERO;
        if (!lock_s_q || !stdy_s_q) begin
          state_d = S_HOLDOFF;
          loss_s  = 1'b1;
        end else begin
          state_d = S_RUN;
        end
      end
      S_HOLDOFF: begin
        if (cnt_q == HOLDOFF_LAST) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = CTR_ZERO;
        end else begin
          cnt_d = cnt_q + CTR_ONE;
        end
      end
      default: begin
        state_d = S_WAIT_LOCK;
        cnt_d   = CTR_ZERO;
      end
    endcase

    stdy_rst_d  = (state_d == S_ARM);
    sys_rst_n_d = (state_d == S_RUN);
    ready_d     = (state_d == S_RUN);

    // A new loss of lock beats a simultaneous clear request
    if (loss_s) begin
      lost_lock_d = 1'b1;
    end else if (clear_lost) begin
      lost_lock_d = 1'b0;
    end else begin
      lost_lock_d = lost_lock_q;
    end

    if (loss_s && (unlock_count_q != UC_MAX)) begin
      unlock_count_d = unlock_count_q + UC_ONE;
    end else begin
      unlock_count_d = unlock_count_q;
    end
  end

  // State, counter and registered outputs
  always_ff @(posedge clock_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q        <= S_WAIT_LOCK;
      cnt_q          <= CTR_ZERO;
      stdy_rst_q     <= 1'b0;
      sys_rst_n_q    <= 1'b0;
      ready_q        <= 1'b0;
      lost_lock_q    <= 1'b0;
      unlock_count_q <= {CNT_W{1'b0}};
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      stdy_rst_q     <= stdy_rst_d;
      sys_rst_n_q    <= sys_rst_n_d;
      ready_q        <= ready_d;
      lost_lock_q    <= lost_lock_d;
      unlock_count_q <= unlock_count_d;
    end
  end

  assign stdy_rst     = stdy_rst_q;
  assign sys_rst_n    = sys_rst_n_q;
  assign ready        = ready_q;
  assign lost_lock    = lost_lock_q;
  assign unlock_count = unlock_count_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Scoreboard bench for pll_lock_supervisor: expectations are queued when stimulus is applied
// and popped when the corresponding DUT output event is observed.
module tb_pll_lock_supervisor;

  localparam int LSC       = 16;
  localparam int SRC       = 2;
  localparam int TO        = 8;
  localparam int HO        = 4;
  localparam int MODEL_DLY = 3;
  localparam int BUDGET    = 100;
  // Cycles from a (re)rising pll_locked to stdy_rst rising
  localparam int T_ARM     = 2 + 1 + LSC;
  // Cycles from stdy_rst falling to sys_rst_n rising with the PLL model below
  localparam int T_REL     = MODEL_DLY + 2;
  localparam int T_DROP    = 3;
  localparam int T_RELOCK  = HO + 1 + LSC;
  localparam int T_RETRY   = TO + 1 + LSC;

  logic       clk;
  logic       rst_n;
  logic       pll_locked;
  logic       pll_locked_stdy;
  logic       clear_lost;
  logic       stdy_rst;
  logic       sys_rst_n;
  logic       ready;
  logic       lost_lock;
  logic [1:0] unlock_count;

  logic stdy_kill;
  logic stdy_en;
  logic stdy_armed;
  int   stdy_dly;
  int   rises;
  int   ready_mism;
  logic prev_rst_n_out;

  int n_checks;
  int n_pass;

  typedef struct {
    string tag;
    int    val;
  } exp_t;
  exp_t sb_q[$];

  pll_lock_supervisor #(
    .LOCK_STABLE_CYCLES(LSC),
    .STDY_RST_CYCLES   (SRC),
    .STDY_TIMEOUT      (TO),
    .HOLDOFF_CYCLES    (HO),
    .CNT_W             (2)
  ) dut (
    .clock_in       (clk),
    .rst_n_in       (rst_n),
    .pll_locked     (pll_locked),
    .pll_locked_stdy(pll_locked_stdy),
    .clear_lost     (clear_lost),
    .stdy_rst       (stdy_rst),
    .sys_rst_n      (sys_rst_n),
    .ready          (ready),
    .lost_lock      (lost_lock),
    .unlock_count   (unlock_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input int val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop(input int obs);
    exp_t e;
    if (sb_q.size() == 0) begin
      check_val("sb_empty", sb_q.size(), 1);
    end else begin
      e = sb_q.pop_front();
      check_val(e.tag, obs, e.val);
    end
  endtask

  // which: 0 = stdy_rst, 1 = sys_rst_n; n = negedges until value seen, BUDGET+1 on timeout
  task automatic wait_sig(input int which, input logic val, output int n);
    int   i;
    logic cur;
    i = 0;
    n = BUDGET + 1;
    while (i < BUDGET) begin
      @(negedge clk);
      i++;
      cur = (which == 0) ? stdy_rst : sys_rst_n;
      if (cur == val) begin
        n = i;
        i = BUDGET;
      end
    end
  endtask

  // PLL sticky-steady flag model: cleared by stdy_rst, set MODEL_DLY cycles after it falls
  initial begin
    pll_locked_stdy = 1'b0;
    stdy_armed      = 1'b0;
    stdy_dly        = 0;
    forever begin
      @(negedge clk);
      #1;
      if (stdy_rst) begin
        stdy_armed      = 1'b1;
        stdy_dly        = 0;
        pll_locked_stdy = 1'b0;
      end else if (!pll_locked || stdy_kill) begin
        stdy_armed      = 1'b0;
        stdy_dly        = 0;
        pll_locked_stdy = 1'b0;
      end else if (stdy_armed && stdy_en) begin
        stdy_dly++;
        if (stdy_dly == MODEL_DLY) begin
          pll_locked_stdy = 1'b1;
          stdy_armed      = 1'b0;
        end
      end
    end
  end

  // Release counter and ready/sys_rst_n agreement monitor
  initial begin
    rises          = 0;
    ready_mism     = 0;
    prev_rst_n_out = 1'b0;
    forever begin
      @(negedge clk);
      if (sys_rst_n && !prev_rst_n_out) rises++;
      prev_rst_n_out = sys_rst_n;
      if (ready !== sys_rst_n) ready_mism++;
    end
  end

  task automatic unlock_by_lock(input string tag, input int exp_cnt);
    int n;
    pll_locked = 1'b0;
    sb_push({tag, "_drop"}, T_DROP);
    sb_push({tag, "_lost"}, 1);
    sb_push({tag, "_count"}, exp_cnt);
    wait_sig(1, 1'b0, n);
    sb_pop(n);
    sb_pop(int'(lost_lock));
    sb_pop(int'(unlock_count));
    pll_locked = 1'b1;
  endtask

  task automatic relock(input string tag, input logic full);
    int n;
    sb_push({tag, "_arm"}, T_RELOCK);
    wait_sig(0, 1'b1, n);
    sb_pop(n);
    if (full) begin
      sb_push({tag, "_width"}, SRC);
      sb_push({tag, "_release"}, T_REL);
      wait_sig(0, 1'b0, n);
      sb_pop(n);
      wait_sig(1, 1'b1, n);
      sb_pop(n);
    end
  endtask

  initial begin
    int n;
    int r0;
    n_checks   = 0;
    n_pass     = 0;
    rst_n      = 1'b0;
    pll_locked = 1'b0;
    clear_lost = 1'b0;
    stdy_kill  = 1'b0;
    stdy_en    = 1'b1;
    repeat (3) @(negedge clk);

    sb_push("rst_sys_rst_n", 0);
    sb_push("rst_ready", 0);
    sb_push("rst_stdy_rst", 0);
    sb_push("rst_lost", 0);
    sb_push("rst_count", 0);
    sb_pop(int'(sys_rst_n));
    sb_pop(int'(ready));
    sb_pop(int'(stdy_rst));
    sb_pop(int'(lost_lock));
    sb_pop(int'(unlock_count));

    // Clean lock from reset
    rst_n      = 1'b1;
    pll_locked = 1'b1;
    sb_push("t1_arm", T_ARM);
    sb_push("t1_width", SRC);
    sb_push("t1_release", T_REL);
    wait_sig(0, 1'b1, n);
    sb_pop(n);
    wait_sig(0, 1'b0, n);
    sb_pop(n);
    wait_sig(1, 1'b1, n);
    sb_pop(n);
    sb_push("t1_ready", 1);
    sb_push("t1_count", 0);
    sb_push("t1_lost", 0);
    sb_push("t1_rises", 1);
    sb_pop(int'(ready));
    sb_pop(int'(unlock_count));
    sb_pop(int'(lost_lock));
    sb_pop(rises);

    // Early drop inside STABLE restarts qualification
    rst_n      = 1'b0;
    pll_locked = 1'b0;
    repeat (3) @(negedge clk);
    rst_n      = 1'b1;
    pll_locked = 1'b1;
    repeat (10) @(negedge clk);
    pll_locked = 1'b0;
    @(negedge clk);
    pll_locked = 1'b1;
    sb_push("t2_arm", T_ARM);
    sb_push("t2_lost", 0);
    sb_push("t2_width", SRC);
    sb_push("t2_release", T_REL);
    wait_sig(0, 1'b1, n);
    sb_pop(n);
    sb_pop(int'(lost_lock));
    wait_sig(0, 1'b0, n);
    sb_pop(n);
    wait_sig(1, 1'b1, n);
    sb_pop(n);

    // Unlock in RUN, then relock
    unlock_by_lock("t3", 1);
    relock("t3", 1'b1);

    // clear_lost clears the flag but not the count
    clear_lost = 1'b1;
    @(negedge clk);
    clear_lost = 1'b0;
    sb_push("clr_lost", 0);
    sb_push("clr_count", 1);
    sb_pop(int'(lost_lock));
    sb_pop(int'(unlock_count));

    // Missed glitch: steady flag drops while lock stays; clear_lost collides with the loss
    stdy_kill = 1'b1;
    @(negedge clk);
    @(negedge clk);
    clear_lost = 1'b1;
    @(negedge clk);
    clear_lost = 1'b0;
    stdy_kill  = 1'b0;
    sb_push("t4_sys_rst_n", 0);
    sb_push("t4_lost_set_wins", 1);
    sb_push("t4_count", 2);
    sb_pop(int'(sys_rst_n));
    sb_pop(int'(lost_lock));
    sb_pop(int'(unlock_count));
    relock("t4", 1'b1);

    // Steady timeout: ARM repeats, no release
    stdy_en = 1'b0;
    r0 = rises;
    unlock_by_lock("t5", 3);
    relock("t5", 1'b0);
    sb_push("t5_width", SRC);
    sb_push("t5_retry", T_RETRY);
    sb_push("t5_sys_rst_n", 0);
    sb_push("t5_no_release", r0);
    wait_sig(0, 1'b0, n);
    sb_pop(n);
    wait_sig(0, 1'b1, n);
    sb_pop(n);
    sb_pop(int'(sys_rst_n));
    sb_pop(rises);
    stdy_en = 1'b1;
    sb_push("t5_width2", SRC);
    sb_push("t5_release", T_REL);
    wait_sig(0, 1'b0, n);
    sb_pop(n);
    wait_sig(1, 1'b1, n);
    sb_pop(n);

    // Saturation, then async reset in the middle of ARM
    unlock_by_lock("sat4", 3);
    relock("sat4", 1'b1);
    unlock_by_lock("sat5", 3);
    relock("sat5", 1'b0);
    @(negedge clk);
    sb_push("t6_mid_arm", 1);
    sb_pop(int'(stdy_rst));
    rst_n = 1'b0;
    #1;
    sb_push("t6_stdy_rst", 0);
    sb_push("t6_sys_rst_n", 0);
    sb_push("t6_ready", 0);
    sb_push("t6_lost", 0);
    sb_push("t6_count", 0);
    sb_pop(int'(stdy_rst));
    sb_pop(int'(sys_rst_n));
    sb_pop(int'(ready));
    sb_pop(int'(lost_lock));
    sb_pop(int'(unlock_count));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sb_push("t6_rearm", T_ARM);
    wait_sig(0, 1'b1, n);
    sb_pop(n);

    sb_push("ready_tracks_sys_rst_n", 0);
    sb_pop(ready_mism);
    check_val("sb_drain", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
